// File: rtl/data_mem_arbiter_pkg.sv
// rtl/data_mem_arbiter_pkg.sv - shared types, owner ids, funct3 codes and access legality for data_mem_arbiter
package data_mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    localparam logic OWNER_CPU = 1'b0;
    localparam logic OWNER_DBG = 1'b1;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    // Unsigned loads have no store counterpart, so LBU/LHU encodings are rejected for stores.
    function automatic logic access_legal(input logic [2:0] funct3, input logic we,
                                          input logic [1:0] addr_lo);
        logic ok;
        case (funct3)
            F3_LB:   ok = 1'b1;
            F3_LH:   ok = ~addr_lo[0];
            F3_LW:   ok = (addr_lo == 2'b00);
            F3_LBU:  ok = ~we;
            F3_LHU:  ok = ~we & ~addr_lo[0];
            default: ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/data_mem_arbiter_if.sv
// rtl/data_mem_arbiter_if.sv - requester, response and memory-side signals of data_mem_arbiter
interface data_mem_arbiter_if;
    logic        cpu_req;
    logic        cpu_we;
    logic [2:0]  cpu_funct3;
    logic [31:0] cpu_endereco;
    logic [31:0] cpu_write_data;
    logic        cpu_gnt;
    logic        cpu_done;
    logic        cpu_err;
    logic [31:0] cpu_read_data;
    logic        cpu_stall;

    logic        dbg_req;
    logic        dbg_we;
    logic [2:0]  dbg_funct3;
    logic [31:0] dbg_endereco;
    logic [31:0] dbg_write_data;
    logic        dbg_gnt;
    logic        dbg_done;
    logic        dbg_err;
    logic [31:0] dbg_read_data;

    logic        mem_MemRead;
    logic        mem_MemWrite;
    logic [2:0]  mem_funct3;
    logic [31:0] mem_endereco;
    logic [31:0] mem_write_data;
    logic [31:0] mem_read_data;

    // master: the arbiter, which owns the memory strobes and the responses
    modport master (
        input  cpu_req, cpu_we, cpu_funct3, cpu_endereco, cpu_write_data,
               dbg_req, dbg_we, dbg_funct3, dbg_endereco, dbg_write_data, mem_read_data,
        output cpu_gnt, cpu_done, cpu_err, cpu_read_data, cpu_stall,
               dbg_gnt, dbg_done, dbg_err, dbg_read_data,
               mem_MemRead, mem_MemWrite, mem_funct3, mem_endereco, mem_write_data
    );

    modport slave (
        output cpu_req, cpu_we, cpu_funct3, cpu_endereco, cpu_write_data,
               dbg_req, dbg_we, dbg_funct3, dbg_endereco, dbg_write_data, mem_read_data,
        input  cpu_gnt, cpu_done, cpu_err, cpu_read_data, cpu_stall,
               dbg_gnt, dbg_done, dbg_err, dbg_read_data,
               mem_MemRead, mem_MemWrite, mem_funct3, mem_endereco, mem_write_data
    );
endinterface

// File: rtl/data_mem_arbiter_rr_arbiter2.sv
// rtl/data_mem_arbiter_rr_arbiter2.sv - two-way round-robin pick between CPU (bit 0) and DBG (bit 1)
module rr_arbiter2
    import data_mem_arb_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last_owner,
    output logic [1:0] gnt,
    output logic       winner
);
    always_comb begin
        winner = OWNER_CPU;
        if (req == 2'b11) begin
            winner = ~last_owner;
        end else if (req[1]) begin
            winner = OWNER_DBG;
        end
        gnt = 2'b00;
        if (req != 2'b00) begin
            gnt = (winner == OWNER_DBG) ? 2'b10 : 2'b01;
        end
    end
endmodule

// File: rtl/data_mem_arbiter.sv
// rtl/data_mem_arbiter.sv - shares the single-port data memory between the CPU and the debug/loader port
module data_mem_arbiter
    import data_mem_arb_pkg::*;
#(
    parameter int unsigned MEM_LATENCY = 1
) (
    input  logic               clock,
    input  logic               reset,
    data_mem_arbiter_if.master bus
);
    localparam logic [2:0] CNT_LOAD = 3'(MEM_LATENCY - 1);

    state_t      state;
    state_t      state_n;
    logic [2:0]  cnt;
    logic        owner;
    logic        last_owner;
    logic        we_q;
    logic        err_q;
    logic [2:0]  f3_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [31:0] rd_q;

    logic [1:0]  arb_gnt;
    logic        winner;
    logic        win_we;
    logic [2:0]  win_funct3;
    logic [31:0] win_addr;
    logic [31:0] win_wdata;
    logic        win_legal;
    logic        accept;

    rr_arbiter2 u_rr (
        .req        ({bus.dbg_req, bus.cpu_req}),
        .last_owner (last_owner),
        .gnt        (arb_gnt),
        .winner     (winner)
    );

    assign win_we     = (winner == OWNER_DBG) ? bus.dbg_we         : bus.cpu_we;
    assign win_funct3 = (winner == OWNER_DBG) ? bus.dbg_funct3     : bus.cpu_funct3;
    assign win_addr   = (winner == OWNER_DBG) ? bus.dbg_endereco   : bus.cpu_endereco;
    assign win_wdata  = (winner == OWNER_DBG) ? bus.dbg_write_data : bus.cpu_write_data;
    assign win_legal  = access_legal(win_funct3, win_we, win_addr[1:0]);
    assign accept     = (state == IDLE) && (arb_gnt != 2'b00);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Strobes decode from state, so an asynchronous reset drops them immediately.
    always_comb begin
        state_n          = state;
        bus.cpu_gnt      = 1'b0;
        bus.dbg_gnt      = 1'b0;
        bus.cpu_done     = 1'b0;
        bus.dbg_done     = 1'b0;
        bus.cpu_err      = 1'b0;
        bus.dbg_err      = 1'b0;
        bus.mem_MemRead  = 1'b0;
        bus.mem_MemWrite = 1'b0;
        case (state)
            IDLE: begin
                bus.cpu_gnt = arb_gnt[0];
                bus.dbg_gnt = arb_gnt[1];
                if (arb_gnt != 2'b00) begin
                    state_n = win_legal ? ACCESS : RESP;
                end
            end
            ACCESS: begin
                bus.mem_MemRead  = ~we_q;
                bus.mem_MemWrite = we_q & (cnt == CNT_LOAD);
                if (cnt == 3'd0) begin
                    state_n = RESP;
                end
            end
            RESP: begin
                bus.cpu_done = (owner == OWNER_CPU);
                bus.dbg_done = (owner == OWNER_DBG);
                bus.cpu_err  = (owner == OWNER_CPU) & err_q;
                bus.dbg_err  = (owner == OWNER_DBG) & err_q;
                state_n      = IDLE;
            end
            default: state_n = IDLE;
        endcase
        bus.cpu_stall = (bus.cpu_req & ~((state == IDLE) & arb_gnt[0]))
                      | ((state != IDLE) & (owner == OWNER_CPU));
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cnt        <= 3'd0;
            owner      <= OWNER_CPU;
            last_owner <= OWNER_DBG;
            we_q       <= 1'b0;
            err_q      <= 1'b0;
            f3_q       <= 3'd0;
            addr_q     <= 32'd0;
            wdata_q    <= 32'd0;
            rd_q       <= 32'd0;
        end else begin
            if (accept) begin
                owner      <= winner;
                last_owner <= winner;
                we_q       <= win_we;
                err_q      <= ~win_legal;
                f3_q       <= win_funct3;
                addr_q     <= win_addr;
                wdata_q    <= win_wdata;
                cnt        <= win_legal ? CNT_LOAD : 3'd0;
            end else if ((state == ACCESS) && (cnt != 3'd0)) begin
                cnt <= cnt - 3'd1;
            end
            // Stores leave the shared read-data register untouched.
            if ((state == ACCESS) && (cnt == 3'd0) && !we_q) begin
                rd_q <= bus.mem_read_data;
            end
        end
    end

    assign bus.mem_funct3     = f3_q;
    assign bus.mem_endereco   = addr_q;
    assign bus.mem_write_data = wdata_q;
    assign bus.cpu_read_data  = rd_q;
    assign bus.dbg_read_data  = rd_q;
endmodule

// File: tb/tb_data_mem_arbiter.sv
// tb/tb_data_mem_arbiter.sv - directed and random checks of data_mem_arbiter at MEM_LATENCY 1 and 3
module tb_data_mem_arbiter;
    import data_mem_arb_pkg::*;

    logic clock = 1'b0;
    logic reset = 1'b1;
    logic sel = 1'b0;
    logic preload = 1'b1;
    int   lat = 1;
    int   checks = 0;
    int   failures = 0;

    always #5 clock = ~clock;

    logic        cpu_req = 1'b0, cpu_we = 1'b0, dbg_req = 1'b0, dbg_we = 1'b0;
    logic [2:0]  cpu_funct3 = 3'd0, dbg_funct3 = 3'd0;
    logic [31:0] cpu_endereco = 32'd0, cpu_write_data = 32'd0;
    logic [31:0] dbg_endereco = 32'd0, dbg_write_data = 32'd0;

    data_mem_arbiter_if bus1 ();
    data_mem_arbiter_if bus3 ();

    data_mem_arbiter #(.MEM_LATENCY(1)) dut1 (.clock(clock), .reset(reset), .bus(bus1.master));
    data_mem_arbiter #(.MEM_LATENCY(3)) dut3 (.clock(clock), .reset(reset), .bus(bus3.master));

    always_comb begin
        bus1.cpu_req = cpu_req & ~sel;   bus3.cpu_req = cpu_req & sel;
        bus1.dbg_req = dbg_req & ~sel;   bus3.dbg_req = dbg_req & sel;
        bus1.cpu_we = cpu_we;            bus3.cpu_we = cpu_we;
        bus1.cpu_funct3 = cpu_funct3;    bus3.cpu_funct3 = cpu_funct3;
        bus1.cpu_endereco = cpu_endereco;     bus3.cpu_endereco = cpu_endereco;
        bus1.cpu_write_data = cpu_write_data; bus3.cpu_write_data = cpu_write_data;
        bus1.dbg_we = dbg_we;            bus3.dbg_we = dbg_we;
        bus1.dbg_funct3 = dbg_funct3;    bus3.dbg_funct3 = dbg_funct3;
        bus1.dbg_endereco = dbg_endereco;     bus3.dbg_endereco = dbg_endereco;
        bus1.dbg_write_data = dbg_write_data; bus3.dbg_write_data = dbg_write_data;
    end

    logic        o_cpu_gnt, o_cpu_done, o_cpu_err, o_cpu_stall, o_dbg_gnt, o_dbg_done, o_dbg_err;
    logic        o_mr, o_mw;
    logic [31:0] o_cpu_rd, o_dbg_rd, o_addr;
    assign o_cpu_gnt   = sel ? bus3.cpu_gnt       : bus1.cpu_gnt;
    assign o_cpu_done  = sel ? bus3.cpu_done      : bus1.cpu_done;
    assign o_cpu_err   = sel ? bus3.cpu_err       : bus1.cpu_err;
    assign o_cpu_stall = sel ? bus3.cpu_stall     : bus1.cpu_stall;
    assign o_cpu_rd    = sel ? bus3.cpu_read_data : bus1.cpu_read_data;
    assign o_dbg_gnt   = sel ? bus3.dbg_gnt       : bus1.dbg_gnt;
    assign o_dbg_done  = sel ? bus3.dbg_done      : bus1.dbg_done;
    assign o_dbg_err   = sel ? bus3.dbg_err       : bus1.dbg_err;
    assign o_dbg_rd    = sel ? bus3.dbg_read_data : bus1.dbg_read_data;
    assign o_mr        = sel ? bus3.mem_MemRead   : bus1.mem_MemRead;
    assign o_mw        = sel ? bus3.mem_MemWrite  : bus1.mem_MemWrite;
    assign o_addr      = sel ? bus3.mem_endereco  : bus1.mem_endereco;

    // ---------------- memory behind the DUTs (word organised, latency-aware) ----------------
    logic [31:0] mem_w [16];
    int age1 = 0, age3 = 0;

    function automatic logic [31:0] init_word(input int i);
        return (i == 4) ? 32'hDEAD_BEEF : (32'h9E37_79B9 * 32'(i + 1));
    endfunction

    function automatic logic [31:0] extract(input logic [2:0] f3, input logic [31:0] word,
                                            input logic [1:0] lo);
        logic [31:0] w;
        w = word >> (8 * lo);
        case (f3)
            F3_LB:   return {{24{w[7]}}, w[7:0]};
            F3_LH:   return {{16{w[15]}}, w[15:0]};
            F3_LBU:  return {24'd0, w[7:0]};
            F3_LHU:  return {16'd0, w[15:0]};
            default: return w;
        endcase
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [2:0] f3,
                                          input logic [1:0] lo, input logic [31:0] d);
        logic [31:0] m;
        m = (f3[1:0] == 2'd0) ? 32'hFF : (f3[1:0] == 2'd1) ? 32'hFFFF : 32'hFFFF_FFFF;
        m = m << (8 * lo);
        return (old & ~m) | ((d << (8 * lo)) & m);
    endfunction

    always @(posedge clock) begin
        age1 <= bus1.mem_MemRead ? age1 + 1 : 0;
        age3 <= bus3.mem_MemRead ? age3 + 1 : 0;
        if (preload) begin
            for (int i = 0; i < 16; i++) mem_w[i] <= init_word(i);
        end else begin
            if (bus1.mem_MemWrite)
                mem_w[bus1.mem_endereco[5:2]] <= merge(mem_w[bus1.mem_endereco[5:2]],
                    bus1.mem_funct3, bus1.mem_endereco[1:0], bus1.mem_write_data);
            if (bus3.mem_MemWrite)
                mem_w[bus3.mem_endereco[5:2]] <= merge(mem_w[bus3.mem_endereco[5:2]],
                    bus3.mem_funct3, bus3.mem_endereco[1:0], bus3.mem_write_data);
        end
    end

    // Data is only valid once the read strobe has been held for MEM_LATENCY cycles.
    always_comb begin
        bus1.mem_read_data = (age1 == 0) ? extract(bus1.mem_funct3, mem_w[bus1.mem_endereco[5:2]],
                                                   bus1.mem_endereco[1:0]) : 32'hA5A5_5A5A;
        bus3.mem_read_data = (age3 == 2) ? extract(bus3.mem_funct3, mem_w[bus3.mem_endereco[5:2]],
                                                   bus3.mem_endereco[1:0]) : 32'hA5A5_5A5A;
    end

    // ---------------- transaction-level reference model ----------------
    logic [7:0]  ref_mem [64];
    bit          m_busy, m_owner, m_last, m_err, m_we, acc_cpu, acc_dbg;
    int          m_phase, m_acc;
    logic [31:0] m_rd, m_pend, m_addr;

    function automatic int ref_size(input logic [2:0] f3);
        return (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
    endfunction

    function automatic bit ref_legal(input logic [2:0] f3, input logic we, input logic [31:0] a);
        if (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7) return 1'b0;
        if (we && f3[2]) return 1'b0;
        return (a % 32'(ref_size(f3))) == 0;
    endfunction

    function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [31:0] a);
        logic [31:0] v;
        int n;
        n = ref_size(f3);
        v = 32'd0;
        for (int k = n - 1; k >= 0; k--) v = (v << 8) | 32'(ref_mem[int'(a[5:0]) + k]);
        if (!f3[2] && n < 4 && v[8*n-1]) v = v | (32'hFFFF_FFFF << (8 * n));
        return v;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_busy = 0; m_owner = 0; m_last = 1; m_err = 0; m_we = 0;
        m_phase = 0; m_acc = 0; m_rd = 32'd0; acc_cpu = 0; acc_dbg = 0;
    endtask

    // Called at a falling edge with inputs set: checks this cycle, then steps one clock.
    task automatic tick();
        bit c, d, win, any, resp, acc_cyc, legal;
        logic        w;
        logic [2:0]  f;
        logic [31:0] a, wd;
        #1;
        c = cpu_req; d = dbg_req;
        any = !m_busy && (c || d);
        win = (c && d) ? !m_last : d;
        resp = m_busy && (m_phase == m_acc + 1);
        acc_cyc = m_busy && (m_phase <= m_acc);
        check("cpu_gnt", o_cpu_gnt, any && !win);
        check("dbg_gnt", o_dbg_gnt, any && win);
        check("cpu_stall", o_cpu_stall, (c && !(any && !win)) || (m_busy && !m_owner));
        check("cpu_done", o_cpu_done, resp && !m_owner);
        check("dbg_done", o_dbg_done, resp && m_owner);
        check("cpu_err", o_cpu_err, resp && !m_owner && m_err);
        check("dbg_err", o_dbg_err, resp && m_owner && m_err);
        check("mem_read", o_mr, acc_cyc && !m_we);
        check("mem_write", o_mw, acc_cyc && m_we && m_phase == 1);
        check("cpu_rdata", o_cpu_rd, m_rd);
        check("dbg_rdata", o_dbg_rd, m_rd);
        if (acc_cyc) check("mem_addr", o_addr, m_addr);
        acc_cpu = 0; acc_dbg = 0;
        if (m_busy) begin
            if (acc_cyc && m_phase == m_acc && !m_we) m_rd = m_pend;
            if (resp) m_busy = 0;
            else m_phase++;
        end else if (any) begin
            w  = win ? dbg_we : cpu_we;
            f  = win ? dbg_funct3 : cpu_funct3;
            a  = win ? dbg_endereco : cpu_endereco;
            wd = win ? dbg_write_data : cpu_write_data;
            legal = ref_legal(f, w, a);
            m_owner = win; m_last = win; m_we = w; m_addr = a; m_err = !legal;
            m_acc = legal ? lat : 0; m_busy = 1; m_phase = 1;
            if (legal && w)
                for (int k = 0; k < ref_size(f); k++) ref_mem[int'(a[5:0]) + k] = wd[8*k +: 8];
            if (legal && !w) m_pend = ref_load(f, a);
            acc_cpu = !win; acc_dbg = win;
        end
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic do_reset();
        reset = 1; cpu_req = 0; dbg_req = 0;
        model_reset();
        repeat (2) @(negedge clock);
        reset = 0;
    endtask

    task automatic rand_fields(output logic we, output logic [2:0] f3, output logic [31:0] a,
                               output logic [31:0] d);
        we = 1'($urandom_range(0, 1));
        f3 = 3'($urandom_range(0, 7));
        if ((f3 == 3'd3 || f3 >= 3'd6) && $urandom_range(0, 2) != 0) f3 = F3_LW;
        if (we && f3[2] && $urandom_range(0, 1) == 1) f3[2] = 1'b0;
        a = 32'($urandom_range(0, 63));
        if ($urandom_range(0, 1) == 1) a[1:0] = 2'b00;
        d = $urandom;
    endtask

    task automatic run_random(input int n);
        for (int i = 0; i < n; i++) begin
            if (!cpu_req || acc_cpu) begin
                cpu_req = ($urandom_range(0, 3) != 0);
                rand_fields(cpu_we, cpu_funct3, cpu_endereco, cpu_write_data);
            end
            if (!dbg_req || acc_dbg) begin
                dbg_req = ($urandom_range(0, 3) != 0);
                rand_fields(dbg_we, dbg_funct3, dbg_endereco, dbg_write_data);
            end
            tick();
        end
        cpu_req = 0; dbg_req = 0;
        repeat (lat + 3) tick();
    endtask

    initial begin
        for (int i = 0; i < 16; i++) begin
            logic [31:0] wv;
            wv = init_word(i);
            for (int b = 0; b < 4; b++) ref_mem[4*i+b] = wv[8*b +: 8];
        end
        do_reset();
        preload = 0;
        tick();

        // single CPU load, latency 1
        cpu_req = 1; cpu_we = 0; cpu_funct3 = F3_LW; cpu_endereco = 32'h10;
        tick();
        cpu_req = 0;
        tick(); tick();
        check("load_rdata", o_cpu_rd, 32'hDEAD_BEEF);
        check("load_stall", o_cpu_stall, 1'b0);

        // tie from reset, then alternation
        do_reset();
        cpu_req = 1; cpu_we = 0; cpu_funct3 = F3_LW; cpu_endereco = 32'h10;
        dbg_req = 1; dbg_we = 0; dbg_funct3 = F3_LW; dbg_endereco = 32'h20;
        for (int i = 0; i < 12; i++) begin
            #1;
            check("tie_gnt", {o_dbg_gnt, o_cpu_gnt}, (i % 3 != 0) ? 0 : (((i / 3) % 2 == 1) ? 2 : 1));
            tick();
        end
        cpu_req = 0; dbg_req = 0;
        tick();

        // misaligned store rejected, byte load at the same address accepted
        cpu_req = 1; cpu_we = 1; cpu_funct3 = F3_SW; cpu_endereco = 32'h13; cpu_write_data = 32'h1111_2222;
        tick();
        cpu_req = 0;
        #1;
        check("mis_done", o_cpu_done, 1'b1);
        check("mis_err", o_cpu_err, 1'b1);
        check("mis_nowrite", o_mw, 1'b0);
        tick();
        dbg_req = 1; dbg_we = 0; dbg_funct3 = F3_LBU; dbg_endereco = 32'h13;
        tick();
        dbg_req = 0;
        tick(); tick();
        check("lbu_err", o_dbg_err, 1'b0);
        run_random(400);

        // latency 3
        sel = 1; lat = 3;
        do_reset();
        tick();
        dbg_req = 1; dbg_we = 1; dbg_funct3 = F3_SH; dbg_endereco = 32'h22; dbg_write_data = 32'h1234_BEEF;
        tick();
        dbg_req = 0;
        #1; check("sh_write_e1", o_mw, 1'b1);
        tick();
        #1; check("sh_write_e2", o_mw, 1'b0);
        tick(); tick();
        #1; check("sh_done_e4", o_dbg_done, 1'b1);
        tick();
        dbg_req = 1; dbg_we = 0; dbg_funct3 = F3_LHU; dbg_endereco = 32'h22;
        tick();
        dbg_req = 0;
        repeat (4) tick();
        check("lhu_rdata", o_dbg_rd, 32'h0000_BEEF);

        // reset during the second access cycle of a load
        cpu_req = 1; cpu_we = 0; cpu_funct3 = F3_LW; cpu_endereco = 32'h10;
        tick();
        cpu_req = 0;
        tick();
        #1; check("rst_read_before", o_mr, 1'b1);
        #1; reset = 1;
        #1;
        check("rst_read_drop", o_mr, 1'b0);
        check("rst_no_done", o_cpu_done, 1'b0);
        model_reset();
        @(negedge clock);
        reset = 0;
        cpu_req = 1; dbg_req = 1; dbg_we = 0; dbg_funct3 = F3_LW; dbg_endereco = 32'h20;
        #1;
        check("rst_tie_cpu", o_cpu_gnt, 1'b1);
        tick();
        cpu_req = 0;
        for (int k = 0; k < 20 && !acc_dbg; k++) tick();
        check("rst_dbg_served", acc_dbg, 1'b1);
        dbg_req = 0;
        repeat (lat + 2) tick();
        run_random(400);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/data_mem_arbiter.md
# data_mem_arbiter

Two-requester arbiter and sequencer for the single-port `data_memory`, sharing it between the CPU load/store path and a debug/program-loader port. It accepts one access at a time with a valid/grant handshake and round-robin priority. It drives the memory strobes for a configurable number of cycles, returns read data with a completion pulse, and raises `cpu_stall` so the PC can be held. It sits between `cpu` and `data_memory`, replacing the direct connection.

## Interface
- `MEM_LATENCY`, default 1: cycles the memory needs from strobe to valid `read_data`; legal range 1..7.
- `clock` in, 1: the single clock; all state updates on its rising edge.
- `reset` in, 1: asynchronous, active-high.
- `cpu_req` in, 1: CPU access request; held stable with its fields until `cpu_gnt`.
- `cpu_we` in, 1: 1 = store, 0 = load.
- `cpu_funct3` in, 3: access size and signedness, RISC-V encoding.
- `cpu_endereco` in, 32: byte address.
- `cpu_write_data` in, 32: store data.
- `cpu_gnt` out, 1: request accepted at this edge (combinational, IDLE only).
- `cpu_done` out, 1: one-cycle completion pulse.
- `cpu_err` out, 1: valid with `cpu_done`; access was rejected.
- `cpu_read_data` out, 32: load result; valid when `cpu_done & ~cpu_err` and the access was a load.
- `cpu_stall` out, 1: `(cpu_req & ~cpu_gnt) | (state != IDLE & owner == CPU)`.
- `dbg_req`, `dbg_we`, `dbg_funct3`, `dbg_endereco`, `dbg_write_data`, `dbg_gnt`, `dbg_done`, `dbg_err`, `dbg_read_data`: same as the CPU signals, for the debug/loader port. The debug port has no stall output.
- `mem_MemRead` out, 1: memory read strobe.
- `mem_MemWrite` out, 1: memory write strobe.
- `mem_funct3` out, 3: registered `funct3` of the accepted access.
- `mem_endereco` out, 32: registered address of the accepted access.
- `mem_write_data` out, 32: registered store data.
- `mem_read_data` in, 32: data returned by the memory.

## Operation
- **States:** IDLE, ACCESS, RESP.
- **IDLE:**
  - Any `req` high: the winner's `gnt` is asserted combinationally.
  - At the next edge the winner's `we`/`funct3`/`endereco`/`write_data` are latched into the `mem_*` registers, `owner` is recorded and `last_owner` is updated.
  - Aligned and legal access: go to ACCESS, counter loaded with `MEM_LATENCY-1`.
  - Misaligned or illegal access: go straight to RESP with `err` set and no memory strobe.
- **Arbitration:**
  - Only one requester: it wins.
  - Both requesting: the requester that is not `last_owner` wins.
  - `last_owner` resets to DBG, so the CPU wins the first tie.
- **Legality:**
  - `funct3[1:0] == 2'b10` requires `endereco[1:0] == 0`.
  - `funct3[1:0] == 2'b01` requires `endereco[0] == 0`.
  - `funct3` 011, 110, 111 are illegal; 100 and 101 are also illegal when `we = 1`.
- **ACCESS:**
  - Load: `mem_MemRead` is high on every ACCESS cycle.
  - Store: `mem_MemWrite` is high on the first ACCESS cycle only.
  - The counter decrements each cycle. At 0, `mem_read_data` is captured into the shared read-data register and the state goes to RESP.
- **RESP:**
  - The owner's `done` is high; `err` is as latched.
  - `read_data` shows the captured register. It holds its value until the next load capture.
  - Next state is IDLE; `gnt` is never asserted in RESP.
- **Reset value of all outputs:** `gnt`/`done`/`err`/strobes 0, `read_data` 0, `mem_*` 0, state IDLE, counter 0.
- **Reset mid-access:** the access is abandoned, strobes drop asynchronously and no `done` is produced.

## Timing
- Accept edge E: ACCESS occupies cycles E+1..E+MEM_LATENCY, RESP is cycle E+MEM_LATENCY+1, IDLE follows.
- Back-to-back throughput is one access per `MEM_LATENCY+2` cycles.
- Rejected access: RESP is at E+1 and the slot takes 2 cycles.
- A `req` arriving during ACCESS or RESP waits; the requester holds its fields stable.
- Fields changing before `gnt` are don't-care; only values at the accept edge matter.
- Both requesters asserting the same cycle: exactly one `gnt`. The loser is granted in the following IDLE cycle.
- Requester dropping `req` without a `gnt`: no access occurs.

## Structure
- **Package `data_mem_arb_pkg`:**
  - state encoding (IDLE/ACCESS/RESP)
  - owner constants CPU = 0, DBG = 1
  - `funct3` codes LB/LH/LW/LBU/LHU/SB/SH/SW
  - function `access_legal(funct3, we, addr_lo)`
- **Sub-module `rr_arbiter2`:** two-way round-robin with inputs `req[1:0]` and `last_owner`, outputs a one-hot `gnt` and `winner`.

## Test plan
- **Single CPU load:** `MEM_LATENCY=1`, memory word 0x10 = 0xDEADBEEF, CPU LW 0x10 accepted at edge E -> `mem_MemRead` high for 1 cycle; `cpu_done=1`, `cpu_err=0`, `cpu_read_data=0xDEADBEEF` at E+2; `cpu_stall` low after.
- **Tie then alternation:** both request from reset -> CPU granted first. Both keep requesting -> grants alternate DBG, CPU, DBG, each slot 3 cycles apart.
- **Misaligned:** CPU SW at 0x13 -> no `mem_MemWrite`; `cpu_done=1`, `cpu_err=1` at E+1. DBG LBU at 0x13 -> legal, completes.
- **Latency sweep:** `MEM_LATENCY=3`, DBG SH 0x22 = 0xBEEF -> `mem_MemWrite` high only at E+1, `dbg_done` at E+4; a later LHU 0x22 returns 0x0000BEEF.
- **Reset mid-access:** assert `reset` during the second ACCESS cycle of a load -> strobes drop the same cycle, no `done`, CPU wins the next tie.
